// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller:
// forwarding select codes, FSM state encoding and the producer-match helper.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam int WAIT_W = 8;

    // r0 is hardwired to zero, so a producer targeting it never forwards or stalls.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] wreg,
                                       input logic [4:0] src);
        return we && (wreg != 5'd0) && (wreg == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Operand forwarding select for one ALU source register.
// The younger EXE_MEM producer wins over MEM_WB.
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_wreg,
    input  logic       mem_regwe,
    input  logic [4:0] wb_wreg,
    input  logic       wb_regwe,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_REG;
        if (reg_match(mem_regwe, mem_wreg, src)) begin
            fwd_sel = FWD_EXMEM;
        end else if (reg_match(wb_regwe, wb_wreg, src)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles,
// redirect squashing, data-memory freeze with timeout, forwarding and stall count.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwe,
    input  logic             ex_load,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_regwe,
    input  logic             mem_access,
    input  logic             dmem_ack,
    input  logic [4:0]       wb_wreg,
    input  logic             wb_regwe,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_exe_en,
    output logic             id_exe_flush,
    output logic             exe_mem_en,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output ctrl_state_t      dbg_state,
    output logic [WAIT_W-1:0] dbg_wait_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              freeze;
    logic              load_use;
    logic [1:0]        fwd_a_raw;
    logic [1:0]        fwd_b_raw;

    assign timeout_hit = (state == ST_MEM_WAIT) && (wait_cnt == TIMEOUT_CNT);
    assign freeze      = mem_access && !dmem_ack && !timeout_hit;
    assign load_use    = ex_load && ex_regwe && (ex_wreg != 5'd0) &&
                         ((id_use_rs && (id_rs == ex_wreg)) ||
                          (id_use_rt && (id_rt == ex_wreg)));

    // Freeze outranks redirect: EXE is held, so the redirect is re-presented on release.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_exe_en    = 1'b0;
        id_exe_flush = 1'b0;
        exe_mem_en   = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            if (freeze) begin
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_en    = 1'b1;
                id_exe_flush = 1'b1;
                exe_mem_en   = 1'b1;
            end else if (load_use) begin
                id_exe_en    = 1'b1;
                id_exe_flush = 1'b1;
                exe_mem_en   = 1'b1;
            end else begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_exe_en    = 1'b1;
                exe_mem_en   = 1'b1;
            end
        end
    end

    pipeline_ctrl_fwd_unit u_fwd_a (
        .src       (ex_rs),
        .mem_wreg  (mem_wreg),
        .mem_regwe (mem_regwe),
        .wb_wreg   (wb_wreg),
        .wb_regwe  (wb_regwe),
        .fwd_sel   (fwd_a_raw)
    );

    pipeline_ctrl_fwd_unit u_fwd_b (
        .src       (ex_rt),
        .mem_wreg  (mem_wreg),
        .mem_regwe (mem_regwe),
        .wb_wreg   (wb_wreg),
        .wb_regwe  (wb_regwe),
        .fwd_sel   (fwd_b_raw)
    );

    assign fwd_a = rst ? fwd_a_raw : FWD_REG;
    assign fwd_b = rst ? fwd_b_raw : FWD_REG;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (mem_access && !dmem_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // A vanished access request is treated like a completion.
                    if (dmem_ack || !mem_access) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational vector table plus hand-written
// multi-cycle sequences for memory freeze, timeout, redirect and reset.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_flush}
    localparam logic [6:0] CTRL_RUN = 7'b1101010;
    localparam logic [6:0] CTRL_LU  = 7'b0001110;
    localparam logic [6:0] CTRL_RDR = 7'b1111110;
    localparam logic [6:0] CTRL_FRZ = 7'b0000001;
    localparam logic [6:0] CTRL_OFF = 7'b0000000;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic             id_use_rs, id_use_rt, ex_regwe, ex_load, ex_redirect;
    logic             mem_regwe, mem_access, dmem_ack, wb_regwe;
    logic             pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
    logic             exe_mem_en, mem_wb_flush, bus_err;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    ctrl_state_t      dbg_state;
    logic [7:0]       dbg_wait_cnt;

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wreg      (ex_wreg),
        .ex_regwe     (ex_regwe),
        .ex_load      (ex_load),
        .ex_redirect  (ex_redirect),
        .mem_wreg     (mem_wreg),
        .mem_regwe    (mem_regwe),
        .mem_access   (mem_access),
        .dmem_ack     (dmem_ack),
        .wb_wreg      (wb_wreg),
        .wb_regwe     (wb_regwe),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_exe_en    (id_exe_en),
        .id_exe_flush (id_exe_flush),
        .exe_mem_en   (exe_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .bus_err      (bus_err),
        .stall_cnt    (stall_cnt),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_flush};
    endfunction

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       use_rs, use_rt;
        logic [4:0] ex_rs, ex_rt, ex_wreg;
        logic       ex_regwe, ex_load, ex_redirect;
        logic [4:0] mem_wreg;
        logic       mem_regwe;
        logic [4:0] wb_wreg;
        logic       wb_regwe;
        logic [6:0] exp_ctrl;
        logic [1:0] exp_a, exp_b;
    } vec_t;

    function automatic vec_t mk(input int a_id_rs, input int a_id_rt, input int a_use_rs,
                                input int a_use_rt, input int a_ex_rs, input int a_ex_rt,
                                input int a_ex_wreg, input int a_ex_regwe, input int a_ex_load,
                                input int a_redir, input int a_mem_wreg, input int a_mem_we,
                                input int a_wb_wreg, input int a_wb_we, input logic [6:0] e_ctrl,
                                input logic [1:0] e_a, input logic [1:0] e_b);
        vec_t v;
        v.id_rs       = 5'(a_id_rs);
        v.id_rt       = 5'(a_id_rt);
        v.use_rs      = 1'(a_use_rs);
        v.use_rt      = 1'(a_use_rt);
        v.ex_rs       = 5'(a_ex_rs);
        v.ex_rt       = 5'(a_ex_rt);
        v.ex_wreg     = 5'(a_ex_wreg);
        v.ex_regwe    = 1'(a_ex_regwe);
        v.ex_load     = 1'(a_ex_load);
        v.ex_redirect = 1'(a_redir);
        v.mem_wreg    = 5'(a_mem_wreg);
        v.mem_regwe   = 1'(a_mem_we);
        v.wb_wreg     = 5'(a_wb_wreg);
        v.wb_regwe    = 1'(a_wb_we);
        v.exp_ctrl    = e_ctrl;
        v.exp_a       = e_a;
        v.exp_b       = e_b;
        return v;
    endfunction

    // Driver tasks: inputs change on negedge, outputs sampled 2 time units later.
    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_wreg = 0; ex_regwe = 0; ex_load = 0; ex_redirect = 0;
        mem_wreg = 0; mem_regwe = 0; mem_access = 0; dmem_ack = 0;
        wb_wreg = 0; wb_regwe = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_load_use();
        ex_load = 1; ex_regwe = 1; ex_wreg = 5; id_rs = 5; id_use_rs = 1;
    endtask

    vec_t vecs[13];

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Reset held two cycles; outputs forced off even with hazards and matches present
        tick();
        set_load_use();
        ex_rs = 5; mem_wreg = 5; mem_regwe = 1; ex_redirect = 1;
        settle();
        check("reset_ctrl", 32'(ctrl_now()), 32'(CTRL_OFF));
        check("reset_fwd_a", 32'(fwd_a), 32'(FWD_REG));
        tick();
        check("reset_state", 32'(dbg_state), 32'(ST_RUN));
        check("reset_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
        check("reset_bus_err", 32'(bus_err), 32'd0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        // Load-use: exactly one bubble
        rst = 1'b1;
        clear_inputs();
        set_load_use();
        settle();
        check("lu_ctrl", 32'(ctrl_now()), 32'(CTRL_LU));
        tick();
        clear_inputs();
        settle();
        check("lu_after_ctrl", 32'(ctrl_now()), 32'(CTRL_RUN));
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Memory access acked after three wait cycles
        mem_access = 1; dmem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("memwait_freeze", 32'(ctrl_now()), 32'(CTRL_FRZ));
            tick();
        end
        dmem_ack = 1;
        settle();
        check("memwait_ack_ctrl", 32'(ctrl_now()), 32'(CTRL_RUN));
        check("memwait_ack_state", 32'(dbg_state), 32'(ST_MEM_WAIT));
        check("memwait_ack_cnt", 32'(dbg_wait_cnt), 32'd3);
        tick();
        clear_inputs();
        settle();
        check("memwait_done_state", 32'(dbg_state), 32'(ST_RUN));
        check("memwait_done_cnt", 32'(dbg_wait_cnt), 32'd0);
        check("memwait_bus_err", 32'(bus_err), 32'd0);
        check("memwait_stall_cnt", 32'(stall_cnt), 32'd4);

        // Timeout: four freeze cycles, forced release on the fifth
        mem_access = 1; dmem_ack = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            settle();
            check("timeout_freeze", 32'(ctrl_now()), 32'(CTRL_FRZ));
            tick();
        end
        settle();
        check("timeout_release_ctrl", 32'(ctrl_now()), 32'(CTRL_RUN));
        check("timeout_release_cnt", 32'(dbg_wait_cnt), 32'(MEM_TIMEOUT));
        check("timeout_bus_err_pre", 32'(bus_err), 32'd0);
        tick();
        clear_inputs();
        settle();
        check("timeout_bus_err", 32'(bus_err), 32'd1);
        check("timeout_state", 32'(dbg_state), 32'(ST_RUN));
        check("timeout_stall_cnt", 32'(stall_cnt), 32'd8);
        tick(); tick(); tick();
        settle();
        check("timeout_bus_err_held", 32'(bus_err), 32'd1);

        // Redirect during freeze is held, then applied on the ack cycle
        mem_access = 1; dmem_ack = 0; ex_redirect = 1;
        set_load_use();
        settle();
        check("redir_frozen_ctrl", 32'(ctrl_now()), 32'(CTRL_FRZ));
        tick();
        dmem_ack = 1;
        settle();
        check("redir_release_ctrl", 32'(ctrl_now()), 32'(CTRL_RDR));
        tick();
        clear_inputs();
        settle();
        check("redir_stall_cnt", 32'(stall_cnt), 32'd9);
        check("redir_state", 32'(dbg_state), 32'(ST_RUN));

        // Reset mid-MEM_WAIT discards the wait; next access gets the full budget
        mem_access = 1; dmem_ack = 0;
        tick(); tick();
        settle();
        check("rstwait_cnt_before", 32'(dbg_wait_cnt), 32'd2);
        rst = 1'b0;
        settle();
        check("rstwait_ctrl_off", 32'(ctrl_now()), 32'(CTRL_OFF));
        tick();
        rst = 1'b1;
        settle();
        check("rstwait_state", 32'(dbg_state), 32'(ST_RUN));
        check("rstwait_cnt", 32'(dbg_wait_cnt), 32'd0);
        check("rstwait_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rstwait_bus_err", 32'(bus_err), 32'd0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (i != 0) settle();
            check("rstwait_freeze", 32'(ctrl_now()), 32'(CTRL_FRZ));
            tick();
        end
        settle();
        check("rstwait_release", 32'(ctrl_now()), 32'(CTRL_RUN));
        tick();
        clear_inputs();
        settle();
        check("rstwait_stall_after", 32'(stall_cnt), 32'd4);
        check("rstwait_bus_err_after", 32'(bus_err), 32'd1);

        // Stall counter saturates at 2^CNT_W-1
        set_load_use();
        for (int i = 0; i < 11; i++) tick();
        settle();
        check("sat_reach", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) tick();
        settle();
        check("sat_hold", 32'(stall_cnt), 32'd15);
        clear_inputs();
        tick();

        // Combinational vector table (RUN state, no memory access)
        //          id_rs rt urs urt ex_rs rt wreg we ld rdr mem we wb we  ctrl      a          b
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[1]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, CTRL_LU,  FWD_REG,   FWD_REG);
        vecs[2]  = mk(0, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, CTRL_LU,  FWD_REG,   FWD_REG);
        vecs[3]  = mk(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[4]  = mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[5]  = mk(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[6]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[7]  = mk(5, 0, 1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, CTRL_RDR, FWD_REG,   FWD_REG);
        vecs[8]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3, 1, 3, 1, CTRL_RUN, FWD_EXMEM, FWD_REG);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, CTRL_RUN, FWD_REG,   FWD_REG);
        vecs[10] = mk(0, 0, 0, 0, 4, 9, 0, 0, 0, 0, 9, 1, 4, 1, CTRL_RUN, FWD_MEMWB, FWD_EXMEM);
        vecs[11] = mk(0, 0, 0, 0, 6, 6, 0, 0, 0, 0, 6, 0, 6, 1, CTRL_RUN, FWD_MEMWB, FWD_MEMWB);
        vecs[12] = mk(0, 0, 0, 0, 8, 8, 0, 0, 0, 0, 0, 0, 8, 0, CTRL_RUN, FWD_REG,   FWD_REG);
        for (int i = 0; i < 13; i++) exp_q.push_back({vecs[i].exp_ctrl, vecs[i].exp_a, vecs[i].exp_b});

        for (int i = 0; i < 13; i++) begin
            logic [10:0] exp;
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
            id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
            ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_wreg = vecs[i].ex_wreg;
            ex_regwe = vecs[i].ex_regwe; ex_load = vecs[i].ex_load;
            ex_redirect = vecs[i].ex_redirect;
            mem_wreg = vecs[i].mem_wreg; mem_regwe = vecs[i].mem_regwe;
            wb_wreg = vecs[i].wb_wreg; wb_regwe = vecs[i].wb_regwe;
            settle();
            exp = exp_q.pop_front();
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(exp[10:4]));
            check($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(exp[3:2]));
            check($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(exp[1:0]));
            tick();
        end

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
